serial_paralelo_rx: RTL
=======================

Name: serial_paralelo_rx

Overview:
- Receive side of the serial link: deserialises the 1-bit stream from the parallel-to-serial transmitter back into bytes.
- Hunts for the COM comma (8'hBC) to find byte alignment, then requires BC_LOCK consecutive aligned commas before declaring the link active.
- Once active, emits each non-comma byte with a one-cycle valid strobe.
- Runs entirely in the serial (clk32_f) domain; the byte-rate consumer samples data_out on valid_out.

Parameters:
- COMMA, 8'hBC, idle/alignment symbol the transmitter sends whenever its valid_in is low.
- BC_LOCK, 4, consecutive aligned commas required for SYNC→ACTIVE (legal range 1..15).

Ports:
- clk32_f  input  1  serial bit clock; one bit per rising edge.
- reset  input  1  synchronous, active-low reset; sampled on posedge clk32_f.
- data_in  input  1  serial bit, MSB of each byte first.
- data_out  output  8  last received non-comma byte; holds between strobes.
- valid_out  output  1  one-cycle strobe, high when data_out is updated with a new byte.
- active  output  1  link locked; high from lock until reset.
- aligned  output  1  byte boundary found; high in SYNC and ACTIVE.

Behaviour:
- Reset (reset==0 at posedge):
  - sr=0, bit_cnt=0, bc_cnt=0, state=HUNT.
  - data_out=8'h00, valid_out=0, active=0, aligned=0.
  - Reset overrides everything, including mid-byte and while ACTIVE; no partial byte survives.
- Shift register: every non-reset edge, sr <= {sr[6:0], data_in}; nxt denotes {sr[6:0], data_in}.
- All outputs are registered. A byte whose last bit is sampled at edge k is visible (data_out/valid_out/active) after edge k; 1-cycle latency from last bit.
- HUNT:
  - Bit-by-bit sliding search: if nxt==COMMA, go to SYNC with bit_cnt=0, bc_cnt=1, aligned=1.
  - No bytes are emitted in HUNT.
- SYNC:
  - bit_cnt increments mod 8; byte complete when bit_cnt==7 (eighth bit after the previous boundary).
  - On byte complete with nxt==COMMA: bc_cnt++. If bc_cnt+1==BC_LOCK, go to ACTIVE and set active=1.
  - On byte complete with nxt!=COMMA: go to HUNT, bc_cnt=0, aligned=0.
  - BC_LOCK==1: the transition to ACTIVE happens directly from the HUNT detection edge.
- ACTIVE:
  - On byte complete with nxt!=COMMA: data_out<=nxt, valid_out<=1.
  - On byte complete with nxt==COMMA: valid_out<=0, data_out holds.
  - All other edges: valid_out<=0.
  - Non-comma bytes never cause loss of lock; active and aligned stay 1 until reset.
- valid_out is never high on two consecutive cycles (minimum spacing 8 cycles).
- bc_cnt saturates at BC_LOCK; it is unused in ACTIVE.
- A non-comma pattern that contains 8'hBC across a byte boundary is ignored once aligned; the sliding search runs only in HUNT.
- Boundary cases:
  - reset released mid-stream: HUNT until the first comma.
  - Garbage bits before the first comma: ignored.
  - data_in X/Z: no requirement.

Test Plan:
- Reset hold: hold reset=0 for 5 clk32_f edges with random data_in → data_out=8'h00; valid_out, active, aligned all 0.
- Lock: after reset, send 3 junk bits 101, then 4×8'hBC → aligned=1 after the first comma's last bit. active=1 exactly one edge after the 32nd comma bit. valid_out stays 0 throughout.
- Data: after lock, send 8'hBC, 8'hA5, 8'hBC, 8'h3C → valid_out pulses once after the last bit of A5 (data_out=8'hA5), then once after 3C (data_out=8'h3C). data_out holds 8'hA5 through the intermediate comma.
- Broken lock: send 8'hBC, 8'hBC, 8'h12 (before 4 commas) → return to HUNT, aligned=0, active=0. A subsequent 4×8'hBC then locks normally.
- Misaligned comma: prefix 5 bits 11010, then 8'hBC repeated → sliding search aligns on the true comma boundary; active=1 after 4 aligned commas. A byte 8'h5E following lock is received as 8'h5E.
- Reset mid-operation: assert reset during bit 4 of data byte 8'hF0 while ACTIVE → next edge shows all outputs at reset values and no valid_out for the partial byte. After release, 4 commas are needed again before active=1.

Source files
------------

// File: rtl/serial_paralelo_rx_if.sv
// Serial receiver bus: one serial bit in, recovered bytes and link status out.
interface serial_paralelo_rx_if;
   logic       data_in;
   logic [7:0] data_out;
   logic       valid_out;
   logic       active;
   logic       aligned;

   // Source of the serial stream and consumer of the recovered bytes.
   modport master (
      output data_in,
      input  data_out,
      input  valid_out,
      input  active,
      input  aligned
   );

   // The receiver itself.
   modport slave (
      input  data_in,
      output data_out,
      output valid_out,
      output active,
      output aligned
   );
endinterface

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver. Hunts bit by bit for the comma symbol, then
// counts aligned commas until lock. Once locked it emits every non-comma byte
// with a one-cycle strobe. Everything runs in the serial bit clock domain.
module serial_paralelo_rx #(
   parameter logic [7:0]  COMMA   = 8'hBC,
   parameter int unsigned BC_LOCK = 4
) (
   input  logic                 clk32_f,
   input  logic                 reset,
   serial_paralelo_rx_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_ACTIVE = 2'd2
   } state_t;

   localparam logic [3:0] LP_LOCK = 4'(BC_LOCK);

   state_t     r_state;
   logic [7:0] r_sr;
   logic [2:0] r_bit_cnt;
   logic [3:0] r_bc_cnt;
   logic [7:0] r_data_out;
   logic       r_valid_out;

   state_t     w_state_nxt;
   logic [2:0] w_bit_cnt_nxt;
   logic [3:0] w_bc_cnt_nxt;
   logic [7:0] w_data_nxt;
   logic       w_valid_nxt;
   logic [7:0] w_nxt;
   logic       w_is_comma;
   logic       w_byte_done;

   // Byte as it will look once the current bit is shifted in.
   assign w_nxt       = {r_sr[6:0], bus.data_in};
   assign w_is_comma  = (w_nxt == COMMA);
   assign w_byte_done = (r_bit_cnt == 3'd7);

   // Next-state, counters and byte output decode.
   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt + 3'd1;
      w_bc_cnt_nxt  = r_bc_cnt;
      w_data_nxt    = r_data_out;
      w_valid_nxt   = 1'b0;
      case (r_state)
         ST_HUNT: begin
            // Sliding search: any bit position may start a comma.
            w_bit_cnt_nxt = 3'd0;
            if (w_is_comma) begin
               w_bc_cnt_nxt = 4'd1;
               w_state_nxt  = (LP_LOCK == 4'd1) ? ST_ACTIVE : ST_SYNC;
            end
         end
         ST_SYNC: begin
            if (w_byte_done) begin
               if (w_is_comma) begin
                  w_bc_cnt_nxt = r_bc_cnt + 4'd1;
                  if ((r_bc_cnt + 4'd1) == LP_LOCK) begin
                     w_state_nxt = ST_ACTIVE;
                  end
               end else begin
                  // Alignment was wrong or the link dropped: search again.
                  w_bc_cnt_nxt  = 4'd0;
                  w_bit_cnt_nxt = 3'd0;
                  w_state_nxt   = ST_HUNT;
               end
            end
         end
         ST_ACTIVE: begin
            // Lock is sticky; commas are just idle fill.
            if (w_byte_done && !w_is_comma) begin
               w_data_nxt  = w_nxt;
               w_valid_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt   = ST_HUNT;
            w_bit_cnt_nxt = 3'd0;
            w_bc_cnt_nxt  = 4'd0;
         end
      endcase
   end

   // State, shift register and registered outputs; reset drops any partial byte.
   always_ff @(posedge clk32_f) begin
      if (!reset) begin
         r_state     <= ST_HUNT;
         r_sr        <= 8'h00;
         r_bit_cnt   <= 3'd0;
         r_bc_cnt    <= 4'd0;
         r_data_out  <= 8'h00;
         r_valid_out <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_sr        <= w_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_bc_cnt    <= w_bc_cnt_nxt;
         r_data_out  <= w_data_nxt;
         r_valid_out <= w_valid_nxt;
      end
   end

   assign bus.data_out  = r_data_out;
   assign bus.valid_out = r_valid_out;
   assign bus.active    = (r_state == ST_ACTIVE);
   assign bus.aligned   = (r_state != ST_HUNT);

endmodule
